jstk2_spi_responder: RTL and testbench
======================================

# jstk2_spi_responder

SPI-slave emulation of the PMOD JSTK2 joystick, i.e. the responder end of the bus that the joystick reader drives. Placed in a loopback or HIL build, it answers 5-byte JSTK2 frames with programmable X/Y/button values, so the joystick reader, the position-to-servo scaling and the servo chain can be exercised without the physical module. It also decodes the host's set-LED command (0x84).

## Interface
- `SYNC_STAGES`, default 2: flip-flop stages on `CS_n`, `SCK` and `MOSI`. Legal range 2..3.
- `CLK` input, 1 bit: system clock. All logic runs on the rising edge.
- `RST` input, 1 bit: reset, synchronous and active-high.
- `CS_n` input, 1 bit: SPI chip select, active low, asynchronous to `CLK`.
- `SCK` input, 1 bit: SPI clock, mode 0 (CPOL=0, CPHA=0), asynchronous to `CLK`.
- `MOSI` input, 1 bit: host-to-device data, MSB first.
- `MISO` output, 1 bit: device-to-host data, MSB first. Driven 0 when not selected (no tri-state).
- `x_pos_in` input, 10 bits: X value to report.
- `y_pos_in` input, 10 bits: Y value to report.
- `buttons_in` input, 8 bits: button byte to report.
- `frame_done` output, 1 bit: one-cycle pulse when `CS_n` deasserts after a complete 5-byte frame.
- `frame_err` output, 1 bit: one-cycle pulse when `CS_n` deasserts with a partial byte or fewer than 5 bytes.
- `cmd_byte` output, 8 bits: first byte received in the last complete frame.
- `led_r`, `led_g`, `led_b` outputs, 8 bits each: last LED colour commanded.

## Operation
**Input synchronisation and edge detection**
- Synchronised `SCK` and `CS_n` are edge-detected against their previous synchronised value.
- `MOSI` shares the same stage depth as `SCK`, so the two stay aligned.

**State machine: IDLE -> ACTIVE -> IDLE**
- IDLE to ACTIVE on a synced `CS_n` fall. On that cycle:
  - snapshot the inputs into a 40-bit TX register: {`x_pos_in[7:0]`, 6'b0, `x_pos_in[9:8]`, `y_pos_in[7:0]`, 6'b0, `y_pos_in[9:8]`, `buttons_in`};
  - present TX bit 39 on `MISO`;
  - clear the bit counter (6 bits) and the RX byte store.
- Input changes after the snapshot do not affect the frame in flight.

**In ACTIVE**
- Synced `SCK` rise: shift synced `MOSI` into the RX shift register, increment the bit counter.
- Every 8th bit: store the RX byte into slot `bit_count/8 - 1`. Only slots 0..4 are kept.
- Synced `SCK` fall: shift TX left and present the next bit on `MISO`.
- After 40 bits, `MISO` = 0.
- The bit counter saturates at 63, and further bytes are ignored.

**ACTIVE to IDLE on a synced `CS_n` rise**
- `MISO` goes to 0.
- If the bit count ≥ 40 and the count is a multiple of 8:
  - pulse `frame_done`;
  - `cmd_byte` ← RX slot 0;
  - if slot 0 = 0x84, `led_r/g/b` ← slots 1/2/3.
- Otherwise pulse `frame_err` and leave `cmd_byte` and LEDs unchanged.

**Boundary cases**
- An `SCK` edge while in IDLE is ignored.
- `CS_n` rise and an `SCK` edge detected in the same cycle: the `CS_n` rise wins and the `SCK` edge is discarded.
- `RST` mid-frame aborts the frame with no pulse. The block then waits for a fresh `CS_n` fall, so a `CS_n` that is still low after reset is not treated as a new frame.

## Timing
- Reset values:
  - `MISO` = 0, `frame_done` = 0, `frame_err` = 0;
  - `cmd_byte` = 0, `led_r` = `led_g` = `led_b` = 0;
  - state IDLE, counters 0.
- Edge-to-action latency is SYNC_STAGES+1 `CLK` cycles for `CS_n`, `SCK` and `MOSI`.
- `MISO` is valid SYNC_STAGES+1 cycles after `CS_n` falls, or after `SCK` falls.
- Host requirements:
  - SCK high and low phases each ≥ SYNC_STAGES+3 `CLK` periods;
  - `CS_n` fall to first `SCK` rise ≥ SYNC_STAGES+3 periods.
- `frame_done` / `frame_err` assert SYNC_STAGES+1 cycles after the `CS_n` rise, for exactly one cycle.
- `cmd_byte` and `led_*` update on the same cycle as `frame_done`.
- Back-to-back frames: `CS_n` high ≥ SYNC_STAGES+2 cycles.

## Configuration
- `JSTK2_RESP_LED_EN` defined: the 0x84 decode and the `led_r/g/b` registers are built as described.
- Not defined:
  - `led_r/g/b` are tied to 0;
  - RX slots 1..3 are not stored (slot 0 and `cmd_byte` remain);
  - `frame_done` / `frame_err` behaviour is unchanged.

## Test plan
- Reset held 3 cycles with `CS_n`=1 -> `MISO`=0, all outputs 0, no pulses.
- x=830, y=228, buttons=0x01, host sends 5 bytes 0x00 at SCK = CLK/16 -> host receives 0x3E,0x03,0xE4,0x00,0x01; one `frame_done`; `cmd_byte`=0x00.
- Host sends 0x84,0x10,0x20,0x30,0x00 -> after `CS_n` rise `led_r`=0x10, `led_g`=0x20, `led_b`=0x30 (with `JSTK2_RESP_LED_EN`); all 0 without it.
- `x_pos_in` changed from 230 to 224 mid-frame -> the frame still reports 230 (0xE6,0x00); the next frame reports 224 (0xE0,0x00).
- `CS_n` raised after 13 bits -> one `frame_err`, no `frame_done`, `cmd_byte`/LEDs unchanged; the following full frame succeeds.
- Host clocks 7 bytes -> bytes 6-7 read 0x00 on `MISO`; `frame_done` pulses; LED values come from bytes 2-4 only.

Source files
------------

// File: rtl/jstk2_spi_responder.sv
// ---------------------------------------------------------------------------
// jstk2_spi_responder
//
// SPI mode-0 responder that stands in for a PMOD JSTK2 joystick. Each 5-byte
// frame reports a snapshot of the programmable X/Y/button values, and the
// bytes sent by the host are captured so that the set-LED command (0x84) can
// be decoded.
//
// Optional feature macro: JSTK2_RESP_LED_EN
//   defined   : 0x84 decode and led_r/g/b registers are built.
//   undefined : led_r/g/b tie to 0 and only the command byte is captured.
//
// Ports
//   CLK        : system clock, rising edge
//   RST        : synchronous active-high reset
//   CS_n       : SPI chip select, active low, asynchronous to CLK
//   SCK        : SPI clock (CPOL=0, CPHA=0), asynchronous to CLK
//   MOSI       : host-to-device data, MSB first
//   MISO       : device-to-host data, MSB first, 0 when not selected
//   x_pos_in   : 10-bit X value to report
//   y_pos_in   : 10-bit Y value to report
//   buttons_in : button byte to report
//   frame_done : one-cycle pulse at the end of a complete frame
//   frame_err  : one-cycle pulse at the end of a partial/short frame
//   cmd_byte   : first byte of the last complete frame
//   led_r/g/b  : last LED colour commanded
//
// Parameter SYNC_STAGES (2..3): synchroniser depth on CS_n, SCK and MOSI.
// ---------------------------------------------------------------------------
module jstk2_spi_responder #(
    parameter int SYNC_STAGES = 2
) (
    input  logic       CLK,
    input  logic       RST,
    input  logic       CS_n,
    input  logic       SCK,
    input  logic       MOSI,
    output logic       MISO,
    input  logic [9:0] x_pos_in,
    input  logic [9:0] y_pos_in,
    input  logic [7:0] buttons_in,
    output logic       frame_done,
    output logic       frame_err,
    output logic [7:0] cmd_byte,
    output logic [7:0] led_r,
    output logic [7:0] led_g,
    output logic [7:0] led_b
);

    typedef enum logic {
        IDLE   = 1'b0,
        ACTIVE = 1'b1
    } state_t;

    state_t state_q, state_d;

    logic [SYNC_STAGES-1:0] cs_sync, sck_sync, mosi_sync;
    logic                   cs_prev, sck_prev;
    logic                   cs_s, sck_s, mosi_s;
    logic                   cs_fall, cs_rise, sck_rise, sck_fall;

    logic                   start_frame, end_frame, shift_in, shift_out;
    logic                   frame_ok;

    logic [39:0]            tx_sr;
    logic [7:0]             rx_sr, rx_next;
    logic [5:0]             bit_cnt, bit_cnt_inc;
    logic [7:0]             slot0;

    // Bit counter stops at 63 so an over-long frame cannot wrap back into
    // a multiple of 8 that looks complete.
    function automatic logic [5:0] sat_inc6(input logic [5:0] v);
        return (v == 6'd63) ? v : v + 6'd1;
    endfunction

    // ---- synchroniser stages and edge-detect register ----
    // Not reset: after RST the chain already holds the live CS_n level, so a
    // CS_n that stayed low through reset produces no false fall.
    always_ff @(posedge CLK) begin
        cs_sync   <= {cs_sync[SYNC_STAGES-2:0], CS_n};
        sck_sync  <= {sck_sync[SYNC_STAGES-2:0], SCK};
        mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], MOSI};
        cs_prev   <= cs_sync[SYNC_STAGES-1];
        sck_prev  <= sck_sync[SYNC_STAGES-1];
    end

    assign cs_s     = cs_sync[SYNC_STAGES-1];
    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign cs_fall  = cs_prev & ~cs_s;
    assign cs_rise  = ~cs_prev & cs_s;
    assign sck_rise = ~sck_prev & sck_s;
    assign sck_fall = sck_prev & ~sck_s;

    assign rx_next     = {rx_sr[6:0], mosi_s};
    assign bit_cnt_inc = sat_inc6(bit_cnt);
    assign frame_ok    = (bit_cnt >= 6'd40) && (bit_cnt[2:0] == 3'd0);

    // ---- frame state machine ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // A CS_n rise takes priority over any SCK edge seen in the same cycle.
    always_comb begin
        state_d     = state_q;
        start_frame = 1'b0;
        end_frame   = 1'b0;
        shift_in    = 1'b0;
        shift_out   = 1'b0;
        case (state_q)
            IDLE: begin
                if (cs_fall) begin
                    state_d     = ACTIVE;
                    start_frame = 1'b1;
                end
            end
            ACTIVE: begin
                if (cs_rise) begin
                    state_d   = IDLE;
                    end_frame = 1'b1;
                end else begin
                    shift_in  = sck_rise;
                    shift_out = sck_fall;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // ---- shift registers and received-byte slots ----
`ifdef JSTK2_RESP_LED_EN
    logic [7:0] slot1, slot2, slot3;
`endif

    always_ff @(posedge CLK) begin
        if (start_frame) begin
            tx_sr <= {x_pos_in[7:0], 6'b0, x_pos_in[9:8],
                      y_pos_in[7:0], 6'b0, y_pos_in[9:8], buttons_in};
            rx_sr <= 8'h00;
            slot0 <= 8'h00;
`ifdef JSTK2_RESP_LED_EN
            slot1 <= 8'h00;
            slot2 <= 8'h00;
            slot3 <= 8'h00;
`endif
        end else begin
            // Zero fill means MISO reads 0 once all 40 bits have gone out.
            if (shift_out) begin
                tx_sr <= {tx_sr[38:0], 1'b0};
            end
            if (shift_in) begin
                rx_sr <= rx_next;
                case (bit_cnt_inc)
                    6'd8:  slot0 <= rx_next;
`ifdef JSTK2_RESP_LED_EN
                    6'd16: slot1 <= rx_next;
                    6'd24: slot2 <= rx_next;
                    6'd32: slot3 <= rx_next;
`endif
                    default: ;
                endcase
            end
        end
    end

    assign MISO = (state_q == ACTIVE) & tx_sr[39];

    // ---- frame status and command registers ----
    always_ff @(posedge CLK) begin
        if (RST) begin
            bit_cnt    <= 6'd0;
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            cmd_byte   <= 8'h00;
        end else begin
            frame_done <= 1'b0;
            frame_err  <= 1'b0;
            if (start_frame) begin
                bit_cnt <= 6'd0;
            end else if (shift_in) begin
                bit_cnt <= bit_cnt_inc;
            end
            if (end_frame) begin
                if (frame_ok) begin
                    frame_done <= 1'b1;
                    cmd_byte   <= slot0;
                end else begin
                    frame_err  <= 1'b1;
                end
            end
        end
    end

`ifdef JSTK2_RESP_LED_EN
    always_ff @(posedge CLK) begin
        if (RST) begin
            led_r <= 8'h00;
            led_g <= 8'h00;
            led_b <= 8'h00;
        end else if (end_frame && frame_ok && (slot0 == 8'h84)) begin
            led_r <= slot1;
            led_g <= slot2;
            led_b <= slot3;
        end
    end
`else
    assign led_r = 8'h00;
    assign led_g = 8'h00;
    assign led_b = 8'h00;
`endif

endmodule

// File: tb/tb_jstk2_spi_responder.sv
module tb_jstk2_spi_responder;

    localparam int SYNC_STAGES = 2;
    localparam int HALF        = 8;   // SCK = CLK/16

    logic       CLK = 1'b0;
    logic       RST, CS_n, SCK, MOSI;
    logic       MISO;
    logic [9:0] x_pos_in, y_pos_in;
    logic [7:0] buttons_in;
    logic       frame_done, frame_err;
    logic [7:0] cmd_byte, led_r, led_g, led_b;

    jstk2_spi_responder #(.SYNC_STAGES(SYNC_STAGES)) dut (
        .CLK(CLK), .RST(RST), .CS_n(CS_n), .SCK(SCK), .MOSI(MOSI), .MISO(MISO),
        .x_pos_in(x_pos_in), .y_pos_in(y_pos_in), .buttons_in(buttons_in),
        .frame_done(frame_done), .frame_err(frame_err), .cmd_byte(cmd_byte),
        .led_r(led_r), .led_g(led_g), .led_b(led_b)
    );

    always #5 CLK = ~CLK;

    typedef struct {
        bit          ok;
        logic [7:0]  cmd, r, g, b;
        int          nfull;
        logic [63:0] miso;
    } exp_t;

    exp_t        exp_q[$];
    int          tests = 0;
    int          fails = 0;
    bit          led_en;
    logic [63:0] mosi_word;   // host bytes, byte 0 in [63:56]
    logic [63:0] got_word;    // bits captured by the host from MISO
    logic [7:0]  m_cmd = 8'h00, m_r = 8'h00, m_g = 8'h00, m_b = 8'h00;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, got, exp);
        end
    endtask

    // Reference: the joystick reports X low byte, X high bits, Y low byte,
    // Y high bits, buttons; anything clocked past that reads as zero.
    function automatic logic [63:0] ref_miso(input int x, input int y, input int b);
        logic [7:0] xl, xh, yl, yh, bb;
        xl = 8'(x % 256); xh = 8'(x / 256);
        yl = 8'(y % 256); yh = 8'(y / 256);
        bb = 8'(b);
        return {xl, xh, yl, yh, bb, 24'h0};
    endfunction

    task automatic run_frame(input int nbits, input int chg_bit, input logic [9:0] chg_x,
                             input int rst_bit);
        exp_t e;
        int   nb;
        nb      = (nbits > 63) ? 63 : nbits;
        e.ok    = (nb >= 40) && (nb % 8 == 0);
        e.miso  = ref_miso(int'(x_pos_in), int'(y_pos_in), int'(buttons_in));
        e.nfull = (nbits / 8 > 8) ? 8 : nbits / 8;
        if (e.ok && rst_bit < 0) begin
            m_cmd = mosi_word[63:56];
            if (led_en && m_cmd == 8'h84) begin
                m_r = mosi_word[55:48];
                m_g = mosi_word[47:40];
                m_b = mosi_word[39:32];
            end
        end
        e.cmd = m_cmd; e.r = m_r; e.g = m_g; e.b = m_b;
        if (rst_bit < 0) exp_q.push_back(e);

        got_word = 64'h0;
        CS_n = 1'b0;
        MOSI = mosi_word[63];
        repeat (HALF) @(negedge CLK);
        for (int i = 0; i < nbits; i++) begin
            got_word[63-i] = MISO;
            SCK = 1'b1;
            repeat (HALF) @(negedge CLK);
            SCK  = 1'b0;
            MOSI = (i + 1 < nbits) ? mosi_word[62-i] : 1'b0;
            if (i == chg_bit) x_pos_in = chg_x;
            if (i == rst_bit) begin
                RST = 1'b1;
                repeat (3) @(negedge CLK);
                RST = 1'b0;
                m_cmd = 8'h00; m_r = 8'h00; m_g = 8'h00; m_b = 8'h00;
                @(negedge CLK);
                check("miso_after_rst", 64'(MISO), 64'h0);
                check("cmd_after_rst", 64'(cmd_byte), 64'h0);
            end
            repeat (HALF) @(negedge CLK);
        end
        if (rst_bit >= 0) check("miso_cs_low_after_rst", 64'(MISO), 64'h0);
        CS_n = 1'b1;
        repeat (12) @(negedge CLK);
    endtask

    // Monitor: every frame pulse is matched against the oldest expectation.
    initial begin
        exp_t e;
        forever begin
            @(negedge CLK);
            if (frame_done || frame_err) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    fails++;
                    $display("FAIL unexpected_pulse: done=%0b err=%0b, expected no pulse",
                             frame_done, frame_err);
                end else begin
                    e = exp_q.pop_front();
                    check("frame_done", 64'(frame_done), 64'(e.ok));
                    check("frame_err", 64'(frame_err), 64'(!e.ok));
                    check("cmd_byte", 64'(cmd_byte), 64'(e.cmd));
                    check("led_r", 64'(led_r), 64'(e.r));
                    check("led_g", 64'(led_g), 64'(e.g));
                    check("led_b", 64'(led_b), 64'(e.b));
                    for (int k = 0; k < e.nfull; k++)
                        check($sformatf("miso_byte%0d", k),
                              64'(got_word[63-8*k -: 8]), 64'(e.miso[63-8*k -: 8]));
                end
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
`ifdef JSTK2_RESP_LED_EN
        led_en = 1'b1;
`else
        led_en = 1'b0;
`endif
        RST = 1'b1; CS_n = 1'b1; SCK = 1'b0; MOSI = 1'b0;
        x_pos_in = 10'd0; y_pos_in = 10'd0; buttons_in = 8'h00;
        mosi_word = 64'h0;
        repeat (3) @(posedge CLK);
        @(negedge CLK);
        RST = 1'b0;
        check("rst_miso", 64'(MISO), 64'h0);
        check("rst_frame_done", 64'(frame_done), 64'h0);
        check("rst_frame_err", 64'(frame_err), 64'h0);
        check("rst_cmd_byte", 64'(cmd_byte), 64'h0);
        check("rst_led_r", 64'(led_r), 64'h0);
        check("rst_led_g", 64'(led_g), 64'h0);
        check("rst_led_b", 64'(led_b), 64'h0);
        repeat (6) @(negedge CLK);

        // SCK activity while deselected must be ignored
        repeat (3) begin
            SCK = 1'b1; repeat (HALF) @(negedge CLK);
            SCK = 1'b0; repeat (HALF) @(negedge CLK);
        end
        check("idle_sck_miso", 64'(MISO), 64'h0);

        // Reference vector: x=830, y=228, buttons=0x01
        x_pos_in = 10'd830; y_pos_in = 10'd228; buttons_in = 8'h01;
        mosi_word = 64'h0;
        run_frame(40, -1, 10'd0, -1);

        // Set-LED command
        mosi_word = {8'h84, 8'h10, 8'h20, 8'h30, 8'h00, 24'h0};
        run_frame(40, -1, 10'd0, -1);

        // X changes mid-frame; next frame picks it up
        x_pos_in = 10'd230; y_pos_in = 10'(($urandom));
        mosi_word = {$urandom, $urandom};
        run_frame(40, 12, 10'd224, -1);
        run_frame(40, -1, 10'd0, -1);

        // Short frame: 13 bits, then a full frame
        mosi_word = {8'h84, 8'h5A, 8'hA5, 8'h3C, 32'h0};
        run_frame(13, -1, 10'd0, -1);
        mosi_word = {8'h21, 56'h0};
        run_frame(40, -1, 10'd0, -1);

        // Seven bytes: LED values from bytes 2-4 only
        x_pos_in = 10'd1023; y_pos_in = 10'd512; buttons_in = 8'hC3;
        mosi_word = {8'h84, 8'h11, 8'h22, 8'h33, 8'h44, 8'h84, 8'h55, 8'h00};
        run_frame(56, -1, 10'd0, -1);

        // Reset mid-frame aborts silently; following frame works
        mosi_word = {8'h84, 8'h99, 8'h88, 8'h77, 32'h0};
        run_frame(40, 20, x_pos_in, 20);
        mosi_word = {8'h84, 8'h01, 8'h02, 8'h03, 32'h0};
        run_frame(40, -1, 10'd0, -1);

        // Randomized frames
        for (int n = 0; n < 12; n++) begin
            int sel;
            x_pos_in   = 10'($urandom);
            y_pos_in   = 10'($urandom);
            buttons_in = 8'($urandom);
            mosi_word  = {$urandom, $urandom};
            if ($urandom_range(0, 1) == 1) mosi_word[63:56] = 8'h84;
            sel = $urandom_range(0, 3);
            case (sel)
                0:       run_frame(40, -1, 10'd0, -1);
                1:       run_frame(48, -1, 10'd0, -1);
                2:       run_frame(56, -1, 10'd0, -1);
                default: run_frame($urandom_range(1, 39), -1, 10'd0, -1);
            endcase
        end

        repeat (20) @(negedge CLK);
        check("pending_expectations", 64'(exp_q.size()), 64'h0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
